eth_header_parser: RTL and testbench
====================================

ETH_HEADER_PARSER -- requirements
Module: eth_header_parser

Interface
REQ-001 The block SHALL have parameter RGMII_W, default 8, meaning byte-stream data width; only 8 is supported.
REQ-002 The block SHALL have parameter VLAN_EN, default 1, meaning single 802.1Q tag skipping is enabled when 1.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  RGMII_W  received byte, including preamble/SFD.
REQ-006 rx_valid  input  1  byte qualifier; high for the whole frame, low for at least 1 cycle between frames.
REQ-007 hdr_valid  output  1  one-cycle pulse: header decision available.
REQ-008 is_ip  output  1  frame is IPv4 or IPv6; qualified by hdr_valid.
REQ-009 is_ipv6  output  1  frame is IPv6; qualified by hdr_valid.
REQ-010 dst_ip  output  128  destination IP; IPv4 in [31:0], [127:32] zero.
REQ-011 ethertype  output  16  resolved ethertype (inner ethertype if VLAN tag skipped).
REQ-012 frame_abort  output  1  one-cycle pulse: rx_valid fell before a decision.

Function
REQ-013 States SHALL be IDLE, ETH_HDR, IPV4_HDR, IPV6_HDR, WAIT_END.
REQ-014 IDLE: bytes are discarded until rx_valid=1 and rx_data=0xD5 (SFD); then go to ETH_HDR with byte index 0 pointing to the next byte.
REQ-015 Byte index SHALL be a 6-bit counter incremented per valid byte in ETH_HDR/IPV4_HDR/IPV6_HDR; it never wraps (max reached index is 57).
REQ-016 Index 12-13 SHALL form ethertype, first byte in [15:8].
REQ-017 If VLAN_EN=1 and ethertype=0x8100, indices 16-17 SHALL be the ethertype and all following offsets shift by +4 (offset K); a second 0x8100 is treated as non-IP.
REQ-018 Ethertype 0x0800 SHALL go to IPV4_HDR; 0x86DD to IPV6_HDR; any other value SHALL pulse hdr_valid with is_ip=0 in the cycle after its second byte, then go to WAIT_END.
REQ-019 IPV4_HDR: byte 14+K upper nibble SHALL equal 4, else classify non-IP (is_ip=0) at that byte; dst_ip[31:0] from bytes 30+K..33+K, first byte in MSB; IHL and options ignored.
REQ-020 IPV6_HDR: byte 14+K upper nibble SHALL equal 6, else non-IP; dst_ip from bytes 38+K..53+K, first byte in [127:120].
REQ-021 hdr_valid SHALL assert exactly one cycle, the cycle after the last decision byte is sampled (IPv4 no VLAN: byte 33; IPv6 no VLAN: byte 53), then state WAIT_END.
REQ-022 Latency from SFD sample to hdr_valid: IPv4 35 cycles, IPv6 55, non-IP 15, each +4 with VLAN, assuming rx_valid continuous.
REQ-023 is_ip, is_ipv6, dst_ip, ethertype SHALL be registered and held stable from hdr_valid until the next hdr_valid.
REQ-024 WAIT_END SHALL ignore bytes until rx_valid=0, then go to IDLE in the same edge.
REQ-025 rx_valid=0 in ETH_HDR/IPV4_HDR/IPV6_HDR SHALL pulse frame_abort the next cycle, suppress hdr_valid for that frame, and go to IDLE.
REQ-026 hdr_valid and frame_abort SHALL never assert in the same cycle, and at most one of them SHALL assert per frame.
REQ-027 A 0xD5 byte inside ETH_HDR or later SHALL be treated as data, not as SFD.

Reset
REQ-028 While rst=1 the block SHALL enter IDLE, clear the byte counter, and drive hdr_valid=0, frame_abort=0, is_ip=0, is_ipv6=0, dst_ip=0, ethertype=0.
REQ-029 rst asserted mid-frame SHALL discard the frame with no hdr_valid or frame_abort; the parser SHALL resume at the next SFD after rst=0.

Verification
REQ-030 7x0x55, 0xD5, IPv4 frame, dst 192.168.1.10 -> hdr_valid 35 cycles after SFD, is_ip=1, is_ipv6=0, dst_ip=0x...C0A8010A, ethertype=0x0800.
REQ-031 IPv6 frame, dst 2001:0db8::1 -> hdr_valid 55 cycles after SFD, is_ipv6=1, dst_ip=0x20010DB8000000000000000000000001.
REQ-032 ARP frame (0x0806) -> hdr_valid 15 cycles after SFD, is_ip=0, ethertype=0x0806; no second pulse before next frame.
REQ-033 VLAN 0x8100 + IPv4 dst 10.0.0.1 -> hdr_valid 39 cycles after SFD, dst_ip[31:0]=0x0A000001, ethertype=0x0800.
REQ-034 IPv4 frame with rx_valid dropped after byte 20 -> frame_abort one cycle, no hdr_valid; next back-to-back frame (1-cycle gap) parses correctly.
REQ-035 rst pulsed at byte 25 of IPv4 frame -> all outputs 0, no pulses; following frame decoded normally.

Source files
------------

// File: rtl/eth_header_parser.sv
// Classifies Ethernet frames (optional single 802.1Q tag) as IPv4/IPv6/other and extracts dst IP; decision 15/35/55 cycles after SFD, +4 with a tag.
// No backpressure: rx_valid dropping before a decision aborts the frame; decoded fields hold until the next decision.
module eth_header_parser #(
    parameter int unsigned RGMII_W = 8,
    parameter int unsigned VLAN_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RGMII_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic               hdr_valid,
    output logic               is_ip,
    output logic               is_ipv6,
    output logic [127:0]       dst_ip,
    output logic [15:0]        ethertype,
    output logic               frame_abort
);

    localparam logic [7:0]  SFD_BYTE   = 8'hD5;
    localparam logic [15:0] ETYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;

    typedef enum logic [2:0] {
        IDLE,
        ETH_HDR,
        IPV4_HDR,
        IPV6_HDR,
        WAIT_END
    } state_t;

    state_t         state;
    logic [5:0]     idx;
    logic           vlan_seen;
    logic [7:0]     etype_hi;
    logic [15:0]    cur_etype;
    logic [119:0]   dst_shift;

    logic [7:0]     rx_byte;
    logic [5:0]     rel;
    logic [5:0]     idx_next;
    logic [15:0]    rx_etype;

    // rel is the byte offset with any skipped VLAN tag removed
    always_comb begin
        rx_byte  = rx_data[7:0];
        rel      = idx - {3'b000, vlan_seen, 2'b00};
        idx_next = (idx == 6'h3F) ? idx : idx + 6'd1;
        rx_etype = {etype_hi, rx_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            vlan_seen   <= 1'b0;
            etype_hi    <= '0;
            cur_etype   <= '0;
            dst_shift   <= '0;
            hdr_valid   <= 1'b0;
            frame_abort <= 1'b0;
            is_ip       <= 1'b0;
            is_ipv6     <= 1'b0;
            dst_ip      <= '0;
            ethertype   <= '0;
        end else begin
            hdr_valid   <= 1'b0;
            frame_abort <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid && rx_byte == SFD_BYTE) begin
                        state     <= ETH_HDR;
                        idx       <= '0;
                        vlan_seen <= 1'b0;
                    end
                end

                ETH_HDR: begin
                    if (!rx_valid) begin
                        frame_abort <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idx <= idx_next;
                        if (rel == 6'd12) begin
                            etype_hi <= rx_byte;
                        end else if (rel == 6'd13) begin
                            cur_etype <= rx_etype;
                            if (VLAN_EN != 0 && rx_etype == ETYPE_VLAN && !vlan_seen) begin
                                vlan_seen <= 1'b1;
                            end else if (rx_etype == ETYPE_IPV4) begin
                                state <= IPV4_HDR;
                            end else if (rx_etype == ETYPE_IPV6) begin
                                state <= IPV6_HDR;
                            end else begin
                                hdr_valid <= 1'b1;
                                is_ip     <= 1'b0;
                                is_ipv6   <= 1'b0;
                                dst_ip    <= '0;
                                ethertype <= rx_etype;
                                state     <= WAIT_END;
                            end
                        end
                    end
                end

                IPV4_HDR: begin
                    if (!rx_valid) begin
                        frame_abort <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idx <= idx_next;
                        if (rel == 6'd14 && rx_byte[7:4] != 4'd4) begin
                            hdr_valid <= 1'b1;
                            is_ip     <= 1'b0;
                            is_ipv6   <= 1'b0;
                            dst_ip    <= '0;
                            ethertype <= cur_etype;
                            state     <= WAIT_END;
                        end else if (rel >= 6'd30 && rel <= 6'd33) begin
                            dst_shift <= {dst_shift[111:0], rx_byte};
                            if (rel == 6'd33) begin
                                hdr_valid <= 1'b1;
                                is_ip     <= 1'b1;
                                is_ipv6   <= 1'b0;
                                dst_ip    <= {96'd0, dst_shift[23:0], rx_byte};
                                ethertype <= cur_etype;
                                state     <= WAIT_END;
                            end
                        end
                    end
                end

                IPV6_HDR: begin
                    if (!rx_valid) begin
                        frame_abort <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idx <= idx_next;
                        if (rel == 6'd14 && rx_byte[7:4] != 4'd6) begin
                            hdr_valid <= 1'b1;
                            is_ip     <= 1'b0;
                            is_ipv6   <= 1'b0;
                            dst_ip    <= '0;
                            ethertype <= cur_etype;
                            state     <= WAIT_END;
                        end else if (rel >= 6'd38 && rel <= 6'd53) begin
                            dst_shift <= {dst_shift[111:0], rx_byte};
                            if (rel == 6'd53) begin
                                hdr_valid <= 1'b1;
                                is_ip     <= 1'b1;
                                is_ipv6   <= 1'b1;
                                dst_ip    <= {dst_shift, rx_byte};
                                ethertype <= cur_etype;
                                state     <= WAIT_END;
                            end
                        end
                    end
                end

                WAIT_END: begin
                    if (!rx_valid) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_header_parser.sv
// Frame-level bench for eth_header_parser: table of frames with expected decisions, scoreboard-checked at the outputs.
module tb_eth_header_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         hdr_valid;
    logic         is_ip;
    logic         is_ipv6;
    logic [127:0] dst_ip;
    logic [15:0]  ethertype;
    logic         frame_abort;

    always #5 clk = ~clk;

    eth_header_parser #(.RGMII_W(8), .VLAN_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .hdr_valid   (hdr_valid),
        .is_ip       (is_ip),
        .is_ipv6     (is_ipv6),
        .dst_ip      (dst_ip),
        .ethertype   (ethertype),
        .frame_abort (frame_abort)
    );

    // exp_kind: 0 no pulse, 1 hdr_valid, 2 frame_abort
    typedef struct {
        string        name;
        logic [15:0]  etype;
        bit           vlan;
        logic [3:0]   ver;
        logic [127:0] dst;
        int           abort_at;
        int           rst_at;
        int           exp_kind;
        int           exp_lat;
        bit           exp_is_ip;
        bit           exp_is_ipv6;
        logic [127:0] exp_dst;
        logic [15:0]  exp_etype;
    } vec_t;

    typedef struct {
        string        name;
        int           kind;
        int           sfd_cyc;
        int           lat;
        bit           is_ip;
        bit           is_ipv6;
        logic [127:0] dst;
        logic [15:0]  etype;
    } exp_t;

    exp_t         sb_q[$];
    vec_t         vecs[14];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    bit           hold_is_ip = 1'b0;
    bit           hold_is_ipv6 = 1'b0;
    logic [127:0] hold_dst = '0;
    logic [15:0]  hold_etype = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input string name, input int kind, input int lat, input bit ip,
                            input bit ip6, input logic [127:0] dst, input logic [15:0] et);
        exp_t e;
        e.name = name; e.kind = kind; e.sfd_cyc = cyc; e.lat = lat;
        e.is_ip = ip; e.is_ipv6 = ip6; e.dst = dst; e.etype = et;
        sb_q.push_back(e);
    endtask

    task automatic check_hold(input string name);
        check({name, "_hold_is_ip"}, 128'(is_ip), 128'(hold_is_ip));
        check({name, "_hold_is_ipv6"}, 128'(is_ipv6), 128'(hold_is_ipv6));
        check({name, "_hold_dst"}, dst_ip, hold_dst);
        check({name, "_hold_etype"}, 128'(ethertype), 128'(hold_etype));
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        @(negedge clk);
        rx_data  = d;
        rx_valid = v;
    endtask

    // Scoreboard: every decision/abort pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (hdr_valid === 1'b1 || frame_abort === 1'b1) begin
            if (hdr_valid === 1'b1 && frame_abort === 1'b1) begin
                check("dual_pulse", 128'({hdr_valid, frame_abort}), 128'(2'b10));
            end else if (sb_q.size() == 0) begin
                check("unexpected_pulse", 128'({hdr_valid, frame_abort}), 128'(2'b00));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_kind"}, 128'(hdr_valid ? 1 : 2), 128'(e.kind));
                check({e.name, "_latency"}, 128'(cyc - e.sfd_cyc), 128'(e.lat));
                if (e.kind == 1 && hdr_valid === 1'b1) begin
                    check({e.name, "_is_ip"}, 128'(is_ip), 128'(e.is_ip));
                    check({e.name, "_is_ipv6"}, 128'(is_ipv6), 128'(e.is_ipv6));
                    check({e.name, "_dst_ip"}, dst_ip, e.dst);
                    check({e.name, "_ethertype"}, 128'(ethertype), 128'(e.etype));
                end
            end
        end
    end

    task automatic send_frame(input vec_t v);
        logic [7:0] fb [0:79];
        int         flen;
        int         k;
        k = v.vlan ? 4 : 0;
        for (int i = 0; i < 80; i++) fb[i] = 8'(i & 63);
        for (int i = 0; i < 7; i++) fb[i] = 8'h55;
        fb[7] = 8'hD5;
        fb[9] = 8'hD5;  // SFD value inside the MAC header must be plain data
        if (v.vlan) begin
            fb[20] = 8'h81; fb[21] = 8'h00; fb[22] = 8'h00; fb[23] = 8'h05;
        end
        fb[20 + k] = v.etype[15:8];
        fb[21 + k] = v.etype[7:0];
        if (v.etype == 16'h0800) begin
            fb[22 + k] = {v.ver, 4'h5};
            for (int j = 0; j < 4; j++) fb[38 + k + j] = v.dst[31 - 8*j -: 8];
        end else if (v.etype == 16'h86DD) begin
            fb[22 + k] = {v.ver, 4'h0};
            for (int j = 0; j < 16; j++) fb[46 + k + j] = v.dst[127 - 8*j -: 8];
        end
        flen = (v.abort_at >= 0) ? 8 + v.abort_at + 1 : 72;

        for (int i = 0; i < flen; i++) begin
            @(negedge clk);
            if (v.rst_at >= 0 && i == 8 + v.rst_at + 1) begin
                check({v.name, "_rst_flags"}, 128'({hdr_valid, frame_abort, is_ip, is_ipv6}), 128'(0));
                check({v.name, "_rst_dst"}, dst_ip, 128'(0));
                check({v.name, "_rst_etype"}, 128'(ethertype), 128'(0));
            end
            rst      = (v.rst_at >= 0 && i == 8 + v.rst_at);
            rx_data  = fb[i];
            rx_valid = 1'b1;
            if (i == 7) begin
                check({v.name, "_pending_before"}, 128'(sb_q.size()), 128'(0));
                if (v.exp_kind != 0)
                    push_exp(v.name, v.exp_kind, v.exp_lat, v.exp_is_ip, v.exp_is_ipv6, v.exp_dst, v.exp_etype);
            end
        end

        if (v.exp_kind == 1) begin
            hold_is_ip = v.exp_is_ip; hold_is_ipv6 = v.exp_is_ipv6;
            hold_dst = v.exp_dst; hold_etype = v.exp_etype;
        end else if (v.rst_at >= 0) begin
            hold_is_ip = 1'b0; hold_is_ipv6 = 1'b0; hold_dst = '0; hold_etype = '0;
        end
        @(negedge clk);
        check_hold(v.name);
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_hdr_valid", 128'(hdr_valid), 128'(0));
        check("reset_frame_abort", 128'(frame_abort), 128'(0));
        check("reset_is_ip", 128'({is_ip, is_ipv6}), 128'(0));
        check("reset_dst_ip", dst_ip, 128'(0));
        check("reset_ethertype", 128'(ethertype), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0]  = '{"ipv4", 16'h0800, 1'b0, 4'd4, 128'hC0A8010A, -1, -1, 1, 35, 1'b1, 1'b0, 128'hC0A8010A, 16'h0800};
        vecs[1]  = '{"ipv6", 16'h86DD, 1'b0, 4'd6, 128'h20010DB8000000000000000000000001, -1, -1, 1, 55, 1'b1, 1'b1,
                     128'h20010DB8000000000000000000000001, 16'h86DD};
        vecs[2]  = '{"arp", 16'h0806, 1'b0, 4'd0, 128'h0, -1, -1, 1, 15, 1'b0, 1'b0, 128'h0, 16'h0806};
        vecs[3]  = '{"vlan_ipv4", 16'h0800, 1'b1, 4'd4, 128'h0A000001, -1, -1, 1, 39, 1'b1, 1'b0, 128'h0A000001, 16'h0800};
        vecs[4]  = '{"ipv4_abort20", 16'h0800, 1'b0, 4'd4, 128'hC0A80163, 20, -1, 2, 23, 1'b0, 1'b0, 128'h0, 16'h0};
        vecs[5]  = '{"ipv4_b2b", 16'h0800, 1'b0, 4'd4, 128'hC0A80105, -1, -1, 1, 35, 1'b1, 1'b0, 128'hC0A80105, 16'h0800};
        vecs[6]  = '{"ipv4_rst25", 16'h0800, 1'b0, 4'd4, 128'h0A0B0C0E, -1, 25, 0, 0, 1'b0, 1'b0, 128'h0, 16'h0};
        vecs[7]  = '{"ipv4_post_rst", 16'h0800, 1'b0, 4'd4, 128'hAC100001, -1, -1, 1, 35, 1'b1, 1'b0, 128'hAC100001, 16'h0800};
        vecs[8]  = '{"vlan_ipv6", 16'h86DD, 1'b1, 4'd6, 128'hFE80000000000000000000000000ABCD, -1, -1, 1, 59, 1'b1, 1'b1,
                     128'hFE80000000000000000000000000ABCD, 16'h86DD};
        vecs[9]  = '{"ipv4_badver", 16'h0800, 1'b0, 4'd6, 128'h0A000002, -1, -1, 1, 16, 1'b0, 1'b0, 128'h0, 16'h0800};
        vecs[10] = '{"dbl_vlan", 16'h8100, 1'b1, 4'd0, 128'h0, -1, -1, 1, 19, 1'b0, 1'b0, 128'h0, 16'h8100};
        vecs[11] = '{"ipv6_badver", 16'h86DD, 1'b0, 4'd4, 128'h1, -1, -1, 1, 16, 1'b0, 1'b0, 128'h0, 16'h86DD};
        vecs[12] = '{"eth_abort5", 16'h0800, 1'b0, 4'd4, 128'h0, 5, -1, 2, 8, 1'b0, 1'b0, 128'h0, 16'h0};
        vecs[13] = '{"ipv4_after_abort", 16'h0800, 1'b0, 4'd4, 128'h01020304, -1, -1, 1, 35, 1'b1, 1'b0,
                     128'h01020304, 16'h0800};

        foreach (vecs[i]) send_frame(vecs[i]);

        // Non-IP frame whose tail is full of SFD bytes: exactly one decision, nothing restarts in WAIT_END
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
        @(negedge clk);
        check("arp_tail_pending_before", 128'(sb_q.size()), 128'(0));
        rx_data = 8'hD5; rx_valid = 1'b1;
        push_exp("arp_tail", 1, 15, 1'b0, 1'b0, 128'h0, 16'h0806);
        for (int i = 0; i < 12; i++) drive(8'(8'h10 + i), 1'b1);
        drive(8'h08, 1'b1);
        drive(8'h06, 1'b1);
        for (int i = 0; i < 40; i++) drive(8'hD5, 1'b1);
        drive(8'h00, 1'b0);
        hold_is_ip = 1'b0; hold_is_ipv6 = 1'b0; hold_dst = '0; hold_etype = 16'h0806;
        repeat (10) drive(8'h00, 1'b0);
        check_hold("arp_tail");
        check("queue_drained", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
